// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_DIV_W  = 20;
    localparam int unsigned UART_DATA_W = 8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Divisors below 2 would make the half-bit start delay negative.
    function automatic logic [UART_DIV_W-1:0] eff_div(input logic [UART_DIV_W-1:0] div);
        return (div < UART_DIV_W'(2)) ? UART_DIV_W'(2) : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; read data is forced to 0 while empty.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    // A pop frees a slot in the same cycle, so push is allowed when full and popping.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_peripheral.sv
// UART receiver: line synchronizer, mid-bit sampling FSM with optional parity,
// sticky error flags and an RX FIFO popped by core reads.
module uart_rx_peripheral
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   i_uart_clk,
    input  logic                   i_uart_rst_n,
    input  logic [UART_DIV_W-1:0]  i_uart_baud_divisor,
    input  logic                   i_uart_parity_en,
    input  logic                   i_uart_parity_type,
    input  logic                   i_uart_rx_sdata,
    input  logic                   i_uart_rx_rden,
    input  logic                   i_uart_err_clr,
    output logic [UART_DATA_W-1:0] o_uart_rx_pdata,
    output logic                   o_uart_rx_empty,
    output logic                   o_uart_rx_full,
    output logic                   o_uart_parity_err,
    output logic                   o_uart_frame_err,
    output logic                   o_uart_overrun,
    output logic                   o_uart_rx_busy
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;

    rx_state_e              r_state, w_state_nxt;
    logic [UART_DIV_W-1:0]  r_cnt, w_cnt_nxt;
    logic [UART_DIV_W-1:0]  r_div, w_div_nxt;
    logic [UART_DIV_W-1:0]  w_div_eff;
    logic [2:0]             r_idx, w_idx_nxt;
    logic [UART_DATA_W-1:0] r_shift, w_shift_nxt;
    logic                   r_par_en, w_par_en_nxt;
    logic                   r_par_type, w_par_type_nxt;
    logic                   r_par_bad, w_par_bad_nxt;
    logic                   r_push, w_push_nxt;
    logic                   w_sample;
    logic                   w_set_par;
    logic                   w_set_frame;
    logic                   w_set_ovr;
    logic                   r_par_err;
    logic                   r_frame_err;
    logic                   r_ovr;
    logic                   w_full;

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_uart_rx_sdata};
        end
    end

    assign w_rx_s    = r_sync[SYNC_STAGES-1];
    assign w_div_eff = eff_div(i_uart_baud_divisor);
    assign w_sample  = (r_cnt == '0);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_div_nxt      = r_div;
        w_idx_nxt      = r_idx;
        w_shift_nxt    = r_shift;
        w_par_en_nxt   = r_par_en;
        w_par_type_nxt = r_par_type;
        w_par_bad_nxt  = r_par_bad;
        w_push_nxt     = 1'b0;
        w_set_par      = 1'b0;
        w_set_frame    = 1'b0;

        case (r_state)
            IDLE: begin
                // Frame config is frozen here so mid-frame writes cannot corrupt it.
                if (!w_rx_s) begin
                    w_state_nxt    = START;
                    w_div_nxt      = w_div_eff;
                    w_cnt_nxt      = (w_div_eff >> 1) - UART_DIV_W'(1);
                    w_par_en_nxt   = i_uart_parity_en;
                    w_par_type_nxt = i_uart_parity_type;
                    w_par_bad_nxt  = 1'b0;
                end
            end
            START: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt - UART_DIV_W'(1);
                end else if (!w_rx_s) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = r_div - UART_DIV_W'(1);
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt - UART_DIV_W'(1);
                end else begin
                    w_shift_nxt = {w_rx_s, r_shift[UART_DATA_W-1:1]};
                    w_cnt_nxt   = r_div - UART_DIV_W'(1);
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt - UART_DIV_W'(1);
                end else begin
                    if (w_rx_s != (^r_shift ^ (r_par_type == PARITY_ODD))) begin
                        w_par_bad_nxt = 1'b1;
                        w_set_par     = 1'b1;
                    end
                    w_cnt_nxt   = r_div - UART_DIV_W'(1);
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt - UART_DIV_W'(1);
                end else if (w_rx_s) begin
                    w_push_nxt  = !r_par_bad;
                    w_state_nxt = IDLE;
                end else begin
                    w_set_frame = 1'b1;
                    w_state_nxt = BREAK;
                end
            end
            BREAK: begin
                // Hold off until the line recovers so a long break reports one error.
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_div      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_type <= PARITY_EVEN;
            r_par_bad  <= 1'b0;
            r_push     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div      <= w_div_nxt;
            r_idx      <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_type <= w_par_type_nxt;
            r_par_bad  <= w_par_bad_nxt;
            r_push     <= w_push_nxt;
        end
    end

    // A simultaneous pop makes room, so only a push into a full, non-popping FIFO is lost.
    assign w_set_ovr = r_push && w_full && !i_uart_rx_rden;

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_par_err   <= w_set_par   | (r_par_err   & ~i_uart_err_clr);
            r_frame_err <= w_set_frame | (r_frame_err & ~i_uart_err_clr);
            r_ovr       <= w_set_ovr   | (r_ovr       & ~i_uart_err_clr);
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_rx_fifo (
        .i_clk   (i_uart_clk),
        .i_rst_n (i_uart_rst_n),
        .i_push  (r_push),
        .i_wdata (r_shift),
        .i_pop   (i_uart_rx_rden),
        .o_rdata (o_uart_rx_pdata),
        .o_full  (w_full),
        .o_empty (o_uart_rx_empty)
    );

    assign o_uart_rx_full    = w_full;
    assign o_uart_parity_err = r_par_err;
    assign o_uart_frame_err  = r_frame_err;
    assign o_uart_overrun    = r_ovr;
    assign o_uart_rx_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_peripheral.sv
// Scoreboard bench: stimulus queues expected bytes, a monitor pops the FIFO and compares.
module tb_uart_rx_peripheral;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] div = 20'd4;
    logic        par_en = 1'b0;
    logic        par_type = 1'b0;
    logic        sdata = 1'b1;
    logic        rden = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  pdata;
    logic        empty, full, par_err, frame_err, overrun, busy;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    bit          mon_en = 1'b1;

    uart_rx_peripheral #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .i_uart_clk          (clk),
        .i_uart_rst_n        (rst_n),
        .i_uart_baud_divisor (div),
        .i_uart_parity_en    (par_en),
        .i_uart_parity_type  (par_type),
        .i_uart_rx_sdata     (sdata),
        .i_uart_rx_rden      (rden),
        .i_uart_err_clr      (err_clr),
        .o_uart_rx_pdata     (pdata),
        .o_uart_rx_empty     (empty),
        .o_uart_rx_full      (full),
        .o_uart_parity_err   (par_err),
        .o_uart_frame_err    (frame_err),
        .o_uart_overrun      (overrun),
        .o_uart_rx_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop whatever the DUT presents and compare against the scoreboard head.
    always @(negedge clk) begin
        rden = 1'b0;
        if (mon_en && rst_n && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: got 0x%0h expected none", pdata);
            end else begin
                check("rx_byte", {24'd0, pdata}, {24'd0, exp_q.pop_front()});
            end
            rden = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input int bdiv);
        @(negedge clk);
        sdata = b;
        repeat (bdiv - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit pen, input bit pbit,
                              input int bdiv, input int stop_low);
        drive_bit(1'b0, bdiv);
        for (int i = 0; i < 8; i++) drive_bit(data[i], bdiv);
        if (pen) drive_bit(pbit, bdiv);
        for (int i = 0; i < stop_low; i++) drive_bit(1'b0, bdiv);
        drive_bit(1'b1, bdiv);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_pdata"}, pdata, 0);
        check({tag, "_par"}, par_err, 0);
        check({tag, "_frame"}, frame_err, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(4);

        // 8N1, div 4
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 4, 0);
        idle(8);
        wait_drain("drain_a5");
        check("a5_par", par_err, 0);
        check("a5_frame", frame_err, 0);

        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        par_en = 1'b1;
        par_type = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 4, 0);
        idle(8);
        wait_drain("drain_par_ok");
        check("par_ok_flag", par_err, 0);
        send_frame(8'h07, 1'b1, 1'b0, 4, 0);
        idle(12);
        check("par_bad_flag", par_err, 1);
        check("par_bad_empty", empty, 1);
        pulse_clr();
        check("par_clr", par_err, 0);
        par_en = 1'b0;

        // Stop slot low for three bit-times, then high
        send_frame(8'h55, 1'b0, 1'b0, 4, 3);
        idle(12);
        check("ferr_flag", frame_err, 1);
        check("ferr_busy", busy, 0);
        check("ferr_empty", empty, 1);
        pulse_clr();
        idle(8);
        check("ferr_once", frame_err, 0);

        // One-clock glitch on idle line
        @(negedge clk);
        sdata = 1'b0;
        @(negedge clk);
        sdata = 1'b1;
        idle(10);
        check("glitch_busy", busy, 0);
        check("glitch_empty", empty, 1);
        check("glitch_frame", frame_err, 0);
        check("glitch_par", par_err, 0);

        // Overrun: five bytes into a four-entry FIFO with no reads
        mon_en = 1'b0;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b0, 1'b0, 4, 0);
        idle(8);
        check("ovr_full", full, 1);
        check("ovr_flag", overrun, 1);
        for (int b = 1; b <= 4; b++) exp_q.push_back(8'(b));
        mon_en = 1'b1;
        wait_drain("drain_ovr");
        idle(2);
        check("ovr_not_full", full, 0);
        check("ovr_sticky", overrun, 1);
        pulse_clr();
        check("ovr_clr", overrun, 0);

        // Divisor 4 -> 8 mid-frame: current frame keeps 4, next uses 8
        exp_q.push_back(8'h3C);
        fork
            send_frame(8'h3C, 1'b0, 1'b0, 4, 0);
            begin
                idle(12);
                div = 20'd8;
            end
        join
        idle(8);
        wait_drain("drain_div4");
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 1'b0, 8, 0);
        idle(16);
        wait_drain("drain_div8");
        check("div_frame", frame_err, 0);

        // Reset mid-frame with a byte already buffered
        mon_en = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 8, 0);
        idle(16);
        check("pre_rst_empty", empty, 0);
        fork
            send_frame(8'h22, 1'b0, 1'b0, 8, 0);
            begin
                idle(30);
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
            end
        join
        idle(4);
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(40);
        check("post_rst_empty", empty, 1);
        check("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
